mem_bus_arbiter: RTL

- Two-master arbiter for the single external byte-serial memory bus sequencer.
- Master 0 is the CPU; master 1 is an auxiliary requester (loader/debug/DMA).
- Grants one master at a time and forwards its read/write request to the sequencer. Routes the done pulses back to that master only.
- Round-robin fairness, plus a bounded lock so master 1 can run back-to-back transactions.

---
 rtl/mem_bus_arbiter_pkg.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and the byte-serial sequencer.
// The package holds the arbiter state encoding and the master index constants.
// It also holds the data-width-derived address and mask widths for the default
// 16-bit bus, and helper functions that compute them for other widths.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam int RV_DEFAULT = 16;

    // Addresses are word addresses: bits [RV-1:RV/16] of the byte address.
    function automatic int addr_w(input int rv);
        return rv - rv / 16;
    endfunction

    function automatic int mask_w(input int rv);
        return rv / 8;
    endfunction

    localparam int ADDR_W = RV_DEFAULT - RV_DEFAULT / 16;
    localparam int MASK_W = RV_DEFAULT / 8;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the external byte-serial memory bus sequencer.
// Master 0 (CPU) and master 1 (aux: loader/debug/DMA) request with level
// signals. The arbiter grants one master at a time and muxes that master's
// request onto the s_* bus. The sequencer's done pulses go back only to the
// granted master. Arbitration is round-robin. While m1_lock is high, master 1
// may keep the bus for up to LOCK_MAX consecutive grants.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mX_raddr/mX_rreq      master X read address / read request (level)
//   mX_waddr/mX_wmask/    master X write address / byte mask (nonzero = write)
//   mX_wdata              / write data
//   mX_rdone/mX_wdone     done pulses returned to master X
//   m1_lock               master 1 asks to keep its grant
//   rdata                 read data broadcast to both masters
//   s_*                   request to / done from the sequencer
//   gnt                   one-hot current grant, 00 when idle
//
// State | meaning
// IDLE  | no transaction; arbitrate combinationally, grant takes effect next cycle
// BUSY  | granted master's request is on the s_* bus until a done pulse
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int RV       = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [RV-RV/16-1:0]  m0_raddr,
    input  logic                 m0_rreq,
    input  logic [RV-RV/16-1:0]  m0_waddr,
    input  logic [RV/8-1:0]      m0_wmask,
    input  logic [RV-1:0]        m0_wdata,
    output logic                 m0_rdone,
    output logic                 m0_wdone,

    input  logic [RV-RV/16-1:0]  m1_raddr,
    input  logic                 m1_rreq,
    input  logic [RV-RV/16-1:0]  m1_waddr,
    input  logic [RV/8-1:0]      m1_wmask,
    input  logic [RV-1:0]        m1_wdata,
    input  logic                 m1_lock,
    output logic                 m1_rdone,
    output logic                 m1_wdone,

    output logic [RV-1:0]        rdata,

    output logic [RV-RV/16-1:0]  s_raddr,
    output logic                 s_rreq,
    output logic [RV-RV/16-1:0]  s_waddr,
    output logic [RV/8-1:0]      s_wmask,
    output logic [RV-1:0]        s_wdata,
    input  logic [RV-1:0]        s_rdata,
    input  logic                 s_rdone,
    input  logic                 s_wdone,

    output logic [1:0]           gnt
);

    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(LOCK_MAX);

    state_t         state, state_next;
    logic [1:0]     gnt_r, gnt_next;
    logic           last, last_next;
    logic [LCW-1:0] lock_cnt, lock_next;

    logic           req0, req1;
    logic           grant_v;
    logic           pick;
    logic           sel;

    assign req0  = m0_rreq | (|m0_wmask);
    assign req1  = m1_rreq | (|m1_wmask);
    assign sel   = gnt_r[1];
    assign gnt   = gnt_r;
    assign rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt_r    <= 2'b00;
            last     <= M_AUX;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            gnt_r    <= gnt_next;
            last     <= last_next;
            lock_cnt <= lock_next;
        end
    end

    always_comb begin
        state_next = state;
        gnt_next   = gnt_r;
        last_next  = last;
        lock_next  = lock_cnt;
        grant_v    = 1'b0;
        pick       = M_CPU;

        s_raddr    = '0;
        s_rreq     = 1'b0;
        s_waddr    = '0;
        s_wmask    = '0;
        s_wdata    = '0;
        m0_rdone   = 1'b0;
        m0_wdone   = 1'b0;
        m1_rdone   = 1'b0;
        m1_wdone   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    grant_v = 1'b1;
                    if (last == M_AUX && m1_lock && lock_cnt < LOCK_LIMIT) begin
                        pick = M_AUX;
                    end else begin
                        pick = ~last;
                    end
                end else if (req0) begin
                    grant_v = 1'b1;
                    pick    = M_CPU;
                end else if (req1) begin
                    grant_v = 1'b1;
                    pick    = M_AUX;
                end

                if (grant_v) begin
                    state_next = ST_BUSY;
                    gnt_next   = (pick == M_AUX) ? 2'b10 : 2'b01;
                end

                // Every master-1 grant made while lock is held counts toward the
                // limit, including the round-robin one that opens the burst.
                // The count saturates when master 1 is the only requester.
                if (!m1_lock || (grant_v && pick == M_CPU)) begin
                    lock_next = '0;
                end else if (grant_v && pick == M_AUX && lock_cnt != LOCK_LIMIT) begin
                    lock_next = lock_cnt + LCW'(1);
                end
            end

            ST_BUSY: begin
                if (sel == M_AUX) begin
                    s_raddr  = m1_raddr;
                    s_rreq   = m1_rreq;
                    s_waddr  = m1_waddr;
                    s_wmask  = m1_wmask;
                    s_wdata  = m1_wdata;
                    m1_rdone = s_rdone;
                    m1_wdone = s_wdone;
                end else begin
                    s_raddr  = m0_raddr;
                    s_rreq   = m0_rreq;
                    s_waddr  = m0_waddr;
                    s_wmask  = m0_wmask;
                    s_wdata  = m0_wdata;
                    m0_rdone = s_rdone;
                    m0_wdone = s_wdone;
                end

                if (s_rdone || s_wdone) begin
                    last_next  = sel;
                    state_next = ST_IDLE;
                    gnt_next   = 2'b00;
                end
            end

            default: begin
                state_next = ST_IDLE;
                gnt_next   = 2'b00;
            end
        endcase
    end

endmodule
